// File: rtl/glb_pkg.sv
// Shared defaults and tag types for the global-buffer BRAM arbiter.
package glb_pkg;

  localparam int unsigned DEF_NUM_REQ      = 4;
  localparam int unsigned DEF_DATA_W       = 8;
  localparam int unsigned DEF_ADDR_W       = 10;
  localparam int unsigned DEF_READ_LATENCY = 2;

  // Requester index width, never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned REQ_ID_W = id_width(DEF_NUM_REQ);

  typedef logic [REQ_ID_W-1:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

endpackage

// File: rtl/glb_rd_tag_pipe.sv
// Per-port read tag pipeline matched to RAM latency; routes returning data to its requester.
module glb_rd_tag_pipe #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned ID_W         = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_valid,
  input  logic [ID_W-1:0]           load_id,
  input  logic [DATA_W-1:0]         ram_dout,
  output logic                      regce,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [NUM_REQ*DATA_W-1:0] rsp_rdata
);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } pipe_tag_t;

  pipe_tag_t [READ_LATENCY-1:0] stage_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= '{valid: load_valid, id: load_id};
      for (int i = 1; i < READ_LATENCY; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  // The output register must capture one cycle before the tag reaches the last stage.
  if (READ_LATENCY > 1) begin : g_regce
    assign regce = stage_q[READ_LATENCY-2].valid;
  end else begin : g_no_regce
    assign regce = 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    if (stage_q[READ_LATENCY-1].valid) begin
      rsp_valid[stage_q[READ_LATENCY-1].id]                   = 1'b1;
      rsp_rdata[stage_q[READ_LATENCY-1].id*DATA_W +: DATA_W] = ram_dout;
    end
  end

endmodule

// File: rtl/glb_bram_arbiter.sv
// Round-robin arbiter granting up to two requesters per cycle onto a true dual-port BRAM,
// with latency-matched read return.
module glb_bram_arbiter
  import glb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = DEF_NUM_REQ,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned READ_LATENCY = DEF_READ_LATENCY
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [NUM_REQ*DATA_W-1:0] rsp_rdata,
  output logic                      ram_ena,
  output logic                      ram_wea,
  output logic [ADDR_W-1:0]         ram_addra,
  output logic [DATA_W-1:0]         ram_dina,
  output logic                      ram_regcea,
  output logic                      ram_rsta,
  input  logic [DATA_W-1:0]         ram_douta,
  output logic                      ram_enb,
  output logic                      ram_web,
  output logic [ADDR_W-1:0]         ram_addrb,
  output logic [DATA_W-1:0]         ram_dinb,
  output logic                      ram_regceb,
  output logic                      ram_rstb,
  input  logic [DATA_W-1:0]         ram_doutb
);

  localparam int unsigned ID_W = id_width(NUM_REQ);

  logic [ID_W-1:0]           rr_q, rr_d;
  logic                      a_gnt, b_gnt;
  logic [ID_W-1:0]           id_a, id_b;
  logic [NUM_REQ-1:0]        a_rsp_valid, b_rsp_valid;
  logic [NUM_REQ*DATA_W-1:0] a_rsp_rdata, b_rsp_rdata;

  always_comb begin : p_arb
    int unsigned idx;
    logic        conflict;
    logic [ID_W-1:0] last;
    a_gnt    = 1'b0;
    b_gnt    = 1'b0;
    id_a     = '0;
    id_b     = '0;
    idx      = 0;
    conflict = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[idx] && !rst) begin
        if (!a_gnt) begin
          a_gnt = 1'b1;
          id_a  = ID_W'(idx);
        end else if (!b_gnt) begin
          // Same-address pairs are only safe when both are reads.
          conflict = (req_addr[idx*ADDR_W +: ADDR_W] == req_addr[id_a*ADDR_W +: ADDR_W]) &&
                     (req_we[idx] || req_we[id_a]);
          if (!conflict) begin
            b_gnt = 1'b1;
            id_b  = ID_W'(idx);
          end
        end
      end
    end
    last = b_gnt ? id_b : id_a;
    rr_d = rr_q;
    if (a_gnt) rr_d = (int'(last) == NUM_REQ - 1) ? '0 : last + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_q <= '0;
    else     rr_q <= rr_d;
  end

  always_comb begin
    req_ready = '0;
    if (a_gnt) req_ready[id_a] = 1'b1;
    if (b_gnt) req_ready[id_b] = 1'b1;
  end

  assign ram_ena   = a_gnt;
  assign ram_wea   = a_gnt & req_we[id_a];
  assign ram_addra = a_gnt ? req_addr[id_a*ADDR_W +: ADDR_W] : '0;
  assign ram_dina  = a_gnt ? req_wdata[id_a*DATA_W +: DATA_W] : '0;
  assign ram_enb   = b_gnt;
  assign ram_web   = b_gnt & req_we[id_b];
  assign ram_addrb = b_gnt ? req_addr[id_b*ADDR_W +: ADDR_W] : '0;
  assign ram_dinb  = b_gnt ? req_wdata[id_b*DATA_W +: DATA_W] : '0;
  assign ram_rsta  = rst;
  assign ram_rstb  = rst;

  glb_rd_tag_pipe #(
    .NUM_REQ      (NUM_REQ),
    .DATA_W       (DATA_W),
    .READ_LATENCY (READ_LATENCY),
    .ID_W         (ID_W)
  ) u_pipe_a (
    .clk        (clk),
    .rst        (rst),
    .load_valid (a_gnt & ~req_we[id_a]),
    .load_id    (id_a),
    .ram_dout   (ram_douta),
    .regce      (ram_regcea),
    .rsp_valid  (a_rsp_valid),
    .rsp_rdata  (a_rsp_rdata)
  );

  glb_rd_tag_pipe #(
    .NUM_REQ      (NUM_REQ),
    .DATA_W       (DATA_W),
    .READ_LATENCY (READ_LATENCY),
    .ID_W         (ID_W)
  ) u_pipe_b (
    .clk        (clk),
    .rst        (rst),
    .load_valid (b_gnt & ~req_we[id_b]),
    .load_id    (id_b),
    .ram_dout   (ram_doutb),
    .regce      (ram_regceb),
    .rsp_valid  (b_rsp_valid),
    .rsp_rdata  (b_rsp_rdata)
  );

  // Port A takes precedence if both ports ever return to one requester together.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp
    assign rsp_valid[i] = a_rsp_valid[i] | b_rsp_valid[i];
    assign rsp_rdata[i*DATA_W +: DATA_W] = a_rsp_valid[i] ? a_rsp_rdata[i*DATA_W +: DATA_W]
                                                          : b_rsp_rdata[i*DATA_W +: DATA_W];
  end

endmodule
